// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS phase-accumulator sequencer.
package dds_ctrl_pkg;

  localparam int FCW_W        = 32;
  localparam int PIPE_LAT_DEF = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    RUN
  } state_t;

endpackage

// File: rtl/dds_fcw_stepper.sv
// Sweep stepper: dwell counter plus 33-bit add/compare with clamp-or-wrap at the stop word.
module dds_fcw_stepper
  import dds_ctrl_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               loop,
  input  logic [FCW_W-1:0]   cur_fcw,
  input  logic [FCW_W-1:0]   start_fcw,
  input  logic [FCW_W-1:0]   step_fcw,
  input  logic [FCW_W-1:0]   stop_fcw,
  input  logic [DWELL_W-1:0] dwell,
  output logic               fcw_load,
  output logic [FCW_W-1:0]   fcw_next,
  output logic               done
);

  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_last;
  logic               halted;
  logic               terminal;
  logic [FCW_W:0]     sum;
  logic               over;
  logic               hit;

  // The carry bit keeps a wrapped 32-bit sum from looking smaller than stop.
  always_comb begin
    dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    terminal   = (dwell_cnt == dwell_last);
    sum        = {1'b0, cur_fcw} + {1'b0, step_fcw};
    over       = sum[FCW_W] || (sum[FCW_W-1:0] > stop_fcw);
    hit        = !sum[FCW_W] && (sum[FCW_W-1:0] == stop_fcw);
    fcw_load   = run && terminal && !halted;
    done       = fcw_load && (over || hit);
    fcw_next   = over ? (loop ? start_fcw : stop_fcw) : sum[FCW_W-1:0];
  end

  // Once a non-looping sweep (or a zero step) has reported done, the word is frozen.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      dwell_cnt <= '0;
      halted    <= 1'b0;
    end else if (terminal) begin
      dwell_cnt <= '0;
      if (done && (!loop || step_fcw == '0)) halted <= 1'b1;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Configuration handshake and LOAD/FILL/RUN sequencing for the pipelined DDS phase accumulator.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int DWELL_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_sweep,
  input  logic               cfg_loop,
  input  logic [FCW_W-1:0]   cfg_init,
  input  logic [FCW_W-1:0]   cfg_fcw_start,
  input  logic [FCW_W-1:0]   cfg_fcw_step,
  input  logic [FCW_W-1:0]   cfg_fcw_stop,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               stop,
  output logic               pa_reset,
  output logic [FCW_W-1:0]   pa_init,
  output logic [FCW_W-1:0]   pa_fcw,
  output logic               phase_valid,
  output logic               sweep_done,
  output logic               busy
);

  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  state_t             state;
  logic [CNT_W-1:0]   fill_cnt;
  logic               sweep_q;
  logic               loop_q;
  logic [FCW_W-1:0]   start_q;
  logic [FCW_W-1:0]   step_q;
  logic [FCW_W-1:0]   stop_q;
  logic [DWELL_W-1:0] dwell_q;

  logic               hs;
  logic               step_run;
  logic               step_load;
  logic               step_done;
  logic [FCW_W-1:0]   step_next;

  assign cfg_ready = ((state == IDLE) || (state == RUN)) && !stop;
  assign hs        = cfg_valid && cfg_ready;
  assign step_run  = (state == RUN) && sweep_q && !hs && !stop;

  dds_fcw_stepper #(
    .DWELL_W(DWELL_W)
  ) u_stepper (
    .clk      (clk),
    .reset    (reset),
    .run      (step_run),
    .loop     (loop_q),
    .cur_fcw  (pa_fcw),
    .start_fcw(start_q),
    .step_fcw (step_q),
    .stop_fcw (stop_q),
    .dwell    (dwell_q),
    .fcw_load (step_load),
    .fcw_next (step_next),
    .done     (step_done)
  );

  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values; a blocking = would leak this cycle's update into later reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      sweep_q     <= 1'b0;
      loop_q      <= 1'b0;
      start_q     <= '0;
      step_q      <= '0;
      stop_q      <= '0;
      dwell_q     <= '0;
      pa_reset    <= 1'b1;
      pa_init     <= '0;
      pa_fcw      <= '0;
      phase_valid <= 1'b0;
      sweep_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (stop) begin
        // Abort keeps pa_init/pa_fcw so the last programmed word stays visible.
        state       <= IDLE;
        pa_reset    <= 1'b1;
        phase_valid <= 1'b0;
        busy        <= 1'b0;
      end else if (hs) begin
        sweep_q     <= cfg_sweep;
        loop_q      <= cfg_loop;
        start_q     <= cfg_fcw_start;
        step_q      <= cfg_fcw_step;
        stop_q      <= cfg_fcw_stop;
        dwell_q     <= cfg_dwell;
        pa_init     <= cfg_init;
        pa_fcw      <= cfg_fcw_start;
        pa_reset    <= 1'b1;
        phase_valid <= 1'b0;
        busy        <= 1'b1;
        state       <= LOAD;
      end else begin
        case (state)
          IDLE: begin
            pa_reset    <= 1'b1;
            phase_valid <= 1'b0;
            busy        <= 1'b0;
          end
          LOAD: begin
            pa_reset <= 1'b0;
            fill_cnt <= '0;
            state    <= FILL;
          end
          FILL: begin
            fill_cnt <= fill_cnt + CNT_W'(1);
            if (fill_cnt == CNT_W'(PIPE_LAT - 1)) begin
              phase_valid <= 1'b1;
              state       <= RUN;
            end
          end
          RUN: begin
            // The accumulator skew-aligns fcw internally, so no refill on steps.
            if (step_load) pa_fcw <= step_next;
            sweep_done <= step_done;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of configurations scored against a value-list model.
module tb_dds_sweep_ctrl;

  localparam int PIPE_LAT = 9;
  localparam int DWELL_W  = 16;
  localparam int RUN_CYC  = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_sweep;
  logic               cfg_loop;
  logic [31:0]        cfg_init;
  logic [31:0]        cfg_fcw_start;
  logic [31:0]        cfg_fcw_step;
  logic [31:0]        cfg_fcw_stop;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               stop;
  logic               pa_reset;
  logic [31:0]        pa_init;
  logic [31:0]        pa_fcw;
  logic               phase_valid;
  logic               sweep_done;
  logic               busy;

  dds_sweep_ctrl #(
    .PIPE_LAT(PIPE_LAT),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_sweep    (cfg_sweep),
    .cfg_loop     (cfg_loop),
    .cfg_init     (cfg_init),
    .cfg_fcw_start(cfg_fcw_start),
    .cfg_fcw_step (cfg_fcw_step),
    .cfg_fcw_stop (cfg_fcw_stop),
    .cfg_dwell    (cfg_dwell),
    .stop         (stop),
    .pa_reset     (pa_reset),
    .pa_init      (pa_init),
    .pa_fcw       (pa_fcw),
    .phase_valid  (phase_valid),
    .sweep_done   (sweep_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               sweep;
    logic               loop;
    logic [31:0]        init;
    logic [31:0]        start;
    logic [31:0]        step;
    logic [31:0]        stop;
    logic [DWELL_W-1:0] dwell;
  } vec_t;

  typedef struct {
    logic [31:0] fcw;
    logic        done;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pa_reset"},    32'(pa_reset),    32'd1);
    check({tag, "_pa_init"},     pa_init,          32'd0);
    check({tag, "_pa_fcw"},      pa_fcw,           32'd0);
    check({tag, "_phase_valid"}, 32'(phase_valid), 32'd0);
    check({tag, "_sweep_done"},  32'(sweep_done),  32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_sweep     = v.sweep;
    cfg_loop      = v.loop;
    cfg_init      = v.init;
    cfg_fcw_start = v.start;
    cfg_fcw_step  = v.step;
    cfg_fcw_stop  = v.stop;
    cfg_dwell     = v.dwell;
  endtask

  // Count cycles until phase_valid, bounded; an expired bound shows as a wrong count.
  task automatic wait_fill(input string tag);
    int n = 0;
    while (phase_valid !== 1'b1 && n < 4 * PIPE_LAT) begin
      tick();
      n++;
    end
    check({tag, "_fill_latency"}, n, PIPE_LAT);
  endtask

  // Model: enumerate the words the sweep visits, then index that list by dwell period.
  task automatic push_expected(input vec_t v, input int n_cyc);
    logic [63:0] vals[$];
    logic [63:0] x;
    int   dl, len, i, j;
    exp_t e;
    dl = (v.dwell == 0) ? 1 : int'(v.dwell);
    if (v.sweep && v.step != 0) begin
      x = {32'd0, v.start};
      while (x <= {32'd0, v.stop}) begin
        vals.push_back(x);
        x = x + {32'd0, v.step};
      end
      if (!v.loop && vals[vals.size()-1] != {32'd0, v.stop}) vals.push_back({32'd0, v.stop});
    end
    len = vals.size();
    for (int k = 0; k < n_cyc; k++) begin
      i = k / dl;
      e.fcw  = v.start;
      e.done = 1'b0;
      if (v.sweep && v.step == 0) begin
        e.done = (k == dl) && (v.start == v.stop);
      end else if (v.sweep) begin
        j = i % len;
        e.fcw = v.loop ? vals[j][31:0] : vals[(i < len - 1) ? i : len - 1][31:0];
        if (k % dl == 0 && i > 0) begin
          if (v.loop) e.done = (j == 0) || (j == len - 1 && vals[len-1] == {32'd0, v.stop});
          else        e.done = (i == ((len == 1) ? 1 : len - 1));
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    exp_t  e;
    tag = $sformatf("v%0d", idx);
    apply_reset();
    drive_cfg(v);
    cfg_valid = 1'b1;
    check({tag, "_cfg_ready_idle"}, 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check({tag, "_load_busy"},     32'(busy),     32'd1);
    check({tag, "_load_pa_reset"}, 32'(pa_reset), 32'd1);
    check({tag, "_load_pa_init"},  pa_init,       v.init);
    check({tag, "_load_pa_fcw"},   pa_fcw,        v.start);
    tick();
    check({tag, "_fill_pa_reset"}, 32'(pa_reset), 32'd0);
    wait_fill(tag);
    push_expected(v, RUN_CYC);
    for (int k = 0; k < RUN_CYC; k++) begin
      e = sb.pop_front();
      check($sformatf("%s_k%0d_fcw", tag, k),  pa_fcw,            e.fcw);
      check($sformatf("%s_k%0d_done", tag, k), 32'(sweep_done),   32'(e.done));
      check($sformatf("%s_k%0d_pv", tag, k),   32'(phase_valid),  32'd1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0100_0000, 32'd0,    32'd0,        16'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1234, 32'd100,       32'd10,   32'd130,      16'd3};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0042, 32'd100,       32'd20,   32'd130,      16'd1};
    vecs[3] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFF0, 32'h20,   32'hFFFF_FFFF, 16'd2};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0007, 32'h10,        32'h8,    32'h20,       16'd0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0001, 32'd50,        32'd0,    32'd50,       16'd4};

    reset = 1'b1;
    cfg_valid = 1'b0;
    stop = 1'b0;
    drive_cfg(vecs[0]);
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // Reconfigure while running a sweep, then reset mid-RUN.
    cfg_sweep = 1'b0;
    cfg_fcw_start = 32'h200;
    cfg_valid = 1'b1;
    check("rcfg_cfg_ready_run", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check("rcfg_load_pv",       32'(phase_valid), 32'd0);
    check("rcfg_load_pa_reset", 32'(pa_reset),    32'd1);
    check("rcfg_load_pa_fcw",   pa_fcw,           32'h200);
    check("rcfg_load_busy",     32'(busy),        32'd1);
    tick();
    check("rcfg_fill_pa_reset", 32'(pa_reset), 32'd0);
    wait_fill("rcfg");
    tick();
    check("rcfg_run_pa_fcw", pa_fcw, 32'h200);
    reset = 1'b1;
    tick();
    check_reset_vals("midrun_reset");
    reset = 1'b0;

    // Abort in FILL at count 4 while a new config is offered: stop wins.
    apply_reset();
    drive_cfg(vecs[0]);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    repeat (4) tick();
    stop = 1'b1;
    cfg_valid = 1'b1;
    cfg_fcw_start = 32'hDEAD_0000;
    check("abort_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    stop = 1'b0;
    cfg_valid = 1'b0;
    check("abort_pa_reset", 32'(pa_reset),    32'd1);
    check("abort_busy",     32'(busy),        32'd0);
    check("abort_pv",       32'(phase_valid), 32'd0);
    check("abort_pa_fcw",   pa_fcw,           32'h0100_0000);
    for (int k = 0; k < 2 * PIPE_LAT; k++) begin
      tick();
      check($sformatf("abort_pv_k%0d", k), 32'(phase_valid), 32'd0);
    end
    check("abort_idle_ready", 32'(cfg_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer for the 32-bit pipelined DDS phase accumulator. Accepts a configuration over a valid/ready handshake, then drives the accumulator's reset, init and fcw inputs. Supports single-tone mode and linear frequency sweep (chirp) mode, and tracks pipeline fill so downstream logic (phase-to-amplitude ROM) knows when the phase output is meaningful. Sits between the host/register block and the phase accumulator.

Parameters:
PIPE_LAT, 9, cycles from accumulator reset release to first valid phase word (7 fcw skew stages + adder stage + output stage)
DWELL_W, 16, width of dwell counter (cycles per sweep step)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
cfg_sweep  in  1  0 = single tone, 1 = sweep
cfg_loop  in  1  sweep mode: 1 = restart at start after reaching stop, 0 = hold at stop
cfg_init  in  32  initial phase loaded into accumulator
cfg_fcw_start  in  32  tone fcw / sweep start fcw
cfg_fcw_step  in  32  unsigned sweep increment
cfg_fcw_stop  in  32  sweep end fcw (unsigned, >= start)
cfg_dwell  in  DWELL_W  cycles per sweep step; 0 treated as 1
stop  in  1  abort; return to IDLE
pa_reset  out  1  synchronous reset to accumulator
pa_init  out  32  accumulator init value
pa_fcw  out  32  accumulator frequency control word
phase_valid  out  1  accumulator phase output valid
sweep_done  out  1  one-cycle pulse when sweep reaches stop
busy  out  1  high in LOAD, FILL, RUN

Behaviour:
- Reset: state IDLE; pa_reset=1, pa_init=0, pa_fcw=0, phase_valid=0, sweep_done=0, busy=0; all config registers cleared.
- cfg_ready = (state==IDLE or RUN) and !stop. All outputs registered except cfg_ready.
- IDLE: pa_reset=1, phase_valid=0. On handshake: latch all cfg_* fields, pa_init<=cfg_init, pa_fcw<=cfg_fcw_start, go LOAD.
- LOAD (exactly 1 cycle): pa_reset=1, busy=1; go FILL with fill counter=0.
- FILL: pa_reset=0; counter increments each cycle; when counter==PIPE_LAT-1, go RUN and set phase_valid=1 on the same edge. phase_valid therefore rises PIPE_LAT cycles after first cycle with pa_reset=0.
- RUN tone mode: pa_fcw held; phase_valid=1.
- RUN sweep mode: dwell counter counts 0..max(dwell,1)-1; on terminal count, next = pa_fcw + step computed at 33 bits. If next > stop (or bit 32 set): loop=1 -> pa_fcw<=start; loop=0 -> pa_fcw<=stop and stepping stops. sweep_done pulses 1 cycle on that same edge; if pa_fcw already equals stop and loop=0, no further pulses. If next==stop exactly, pa_fcw<=stop and sweep_done pulses.
- phase_valid stays 1 across fcw changes (accumulator skew-aligns fcw internally; no refill).
- Handshake in RUN: reconfigure; latch fields, go LOAD (phase_valid<=0 same edge, refill follows).
- stop in any state: go IDLE next edge, phase_valid<=0, pa_reset<=1, busy<=0; pa_fcw/pa_init retain values. stop and cfg_valid same cycle: stop wins, no handshake.
- reset mid-operation overrides everything, returns to reset values next edge.
- step=0 in sweep mode: fcw constant, sweep_done never pulses (unless start==stop, then pulses once at first terminal count).

Decomposition:
- Package dds_ctrl_pkg: state enum {IDLE, LOAD, FILL, RUN}, PIPE_LAT default constant, FCW_W=32.
- Sub-module dds_fcw_stepper: dwell counter + 33-bit add/compare/clamp/loop logic, outputs next fcw and done pulse; top holds FSM and handshake.

Test Plan:
- Tone: init=0, start=0x0100_0000, sweep=0 -> pa_reset low 1 cycle after LOAD, phase_valid rises exactly 9 cycles later, pa_fcw stays 0x0100_0000.
- Sweep no-loop: start=100, step=10, stop=130, dwell=3 -> pa_fcw 100,110,120,130 each held 3 cycles; sweep_done single pulse when 130 loaded; holds 130.
- Sweep loop with overshoot: start=100, step=20, stop=130, dwell=1 -> 100,120,100,120...; sweep_done pulses at each wrap to 100.
- Overflow: start=0xFFFF_FFF0, step=0x20, stop=0xFFFF_FFFF, loop=0 -> pa_fcw clamps to 0xFFFF_FFFF, sweep_done pulses.
- Abort and collision: stop asserted in FILL at count 4 while cfg_valid=1 -> no handshake, IDLE next cycle, phase_valid never rises, pa_reset=1.
- Reconfigure in RUN: new start=0x200 handshake -> LOAD, phase_valid low next edge, high again 9 cycles after pa_reset release; reset asserted mid-RUN -> all outputs to reset values next edge.
